// File: rtl/fifo_rd_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_if
//  Description : Read-port bundle of the synchronous FIFO (pop strobe, data,
//                empty flag). The reader is the master.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_rd_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  fifo_empty;

    modport master (
        output fifo_rd_en,
        input  fifo_rdata,
        input  fifo_empty
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rdata,
        output fifo_empty
    );
endinterface
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_tx
//  Description : Pops words from a synchronous FIFO and sends each one as a
//                UART frame (start, LSB-first data, optional parity, stop).
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int RD_LATENCY   = 2,
    parameter int PARITY       = 0
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    input  wire logic  tx_en,
    fifo_rd_if.master  fifo,
    output logic       uart_txd,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int LAT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RD_LATENCY - 1);
    localparam logic              ODD_PAR   = (PARITY == 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [BIT_W-1:0]      bit_nxt;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  txd_q, txd_d;
    logic                  rd_en_q, rd_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  baud_last;

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_cnt_d = bit_cnt_q;
        lat_d     = lat_q;
        shift_d   = shift_q;
        par_d     = par_q;
        txd_d     = txd_q;
        rd_en_d   = 1'b0;
        done_d    = 1'b0;
        bit_nxt   = bit_cnt_q + 1'b1;
        baud_last = (baud_q == BAUD_LAST);

        case (state_q)
            ST_IDLE: begin
                txd_d     = 1'b1;
                baud_d    = '0;
                bit_cnt_d = '0;
                lat_d     = '0;
                if (tx_en && !fifo.fifo_empty) begin
                    state_d = ST_FETCH;
                    rd_en_d = 1'b1;
                end
            end
            ST_FETCH: begin
                // First FETCH cycle only retires the pop strobe; the latency
                // count starts from the edge that sampled it.
                if (rd_en_q) begin
                    lat_d = '0;
                end else if (lat_q == LAT_LAST) begin
                    shift_d = fifo.fifo_rdata;
                    par_d   = ODD_PAR ^ (^fifo.fifo_rdata);
                    txd_d   = 1'b0;
                    lat_d   = '0;
                    state_d = ST_START;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            ST_START: begin
                if (baud_last) begin
                    baud_d    = '0;
                    bit_cnt_d = '0;
                    txd_d     = shift_q[0];
                    state_d   = ST_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        if (PARITY != 0) begin
                            txd_d   = par_q;
                            state_d = ST_PARITY;
                        end else begin
                            txd_d   = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        // Index rather than shift so the captured word stays intact.
                        bit_cnt_d = bit_nxt;
                        txd_d     = shift_q[bit_nxt];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    txd_d   = 1'b1;
                    state_d = ST_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_cnt_q <= '0;
            lat_q     <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            txd_q     <= 1'b1;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_cnt_q <= bit_cnt_d;
            lat_q     <= lat_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            txd_q     <= txd_d;
            rd_en_q   <= rd_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign fifo.fifo_rd_en = rd_en_q;
    assign uart_txd        = txd_q;
    assign tx_busy         = busy_q;
    assign tx_done         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_uart_tx
//  Description : Self-checking bench for fifo_uart_tx with a FIFO read-port
//                model, a frame decoder and an expected-word scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int DW    = 8;
    localparam int CPB   = 4;
    localparam int RDL   = 2;
    localparam int NBITS = DW + 2;
    localparam int FRAME = NBITS * CPB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, tx_en;
    logic uart_txd, tx_busy, tx_done;

    fifo_rd_if #(.DATA_WIDTH(DW)) fif ();

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .RD_LATENCY(RDL), .PARITY(0)) dut (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .fifo(fif),
        .uart_txd(uart_txd), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    // Parity variants: FIFO never empty, a frame runs while p_en_* is high.
    logic [DW-1:0] p_data;
    logic p_en_o, p_en_e;
    logic txd_o, busy_o, done_o, txd_e, busy_e, done_e;
    fifo_rd_if #(.DATA_WIDTH(DW)) pif_o ();
    fifo_rd_if #(.DATA_WIDTH(DW)) pif_e ();
    assign pif_o.fifo_rdata = p_data;
    assign pif_o.fifo_empty = 1'b0;
    assign pif_e.fifo_rdata = p_data;
    assign pif_e.fifo_empty = 1'b0;

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .RD_LATENCY(RDL), .PARITY(1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .tx_en(p_en_o), .fifo(pif_o),
        .uart_txd(txd_o), .tx_busy(busy_o), .tx_done(done_o)
    );
    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .RD_LATENCY(RDL), .PARITY(2)) dut_even (
        .clk(clk), .rst_n(rst_n), .tx_en(p_en_e), .fifo(pif_e),
        .uart_txd(txd_e), .tx_busy(busy_e), .tx_done(done_e)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // FIFO model: data valid only in the cycle before the capture edge.
    logic [DW-1:0] byte_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] st1;
    logic          st1v;
    int pops = 0, underflow = 0;

    always @(posedge clk) begin
        if (fif.fifo_rd_en) begin
            if (byte_q.size() == 0) begin
                underflow++;
                st1v <= 1'b0;
            end else begin
                st1  <= byte_q.pop_front();
                st1v <= 1'b1;
                pops++;
            end
        end else begin
            st1v <= 1'b0;
        end
        fif.fifo_rdata <= st1v ? st1 : DW'($urandom);
    end

    always @(negedge clk) fif.fifo_empty <= (byte_q.size() == 0);

    task automatic push(input logic [DW-1:0] b);
        byte_q.push_back(b);
        exp_q.push_back(b);
    endtask

    // Frame decoder / scoreboard consumer
    logic [FRAME-1:0] smp;
    int mcnt = -1, starts = 0, frames = 0, dones = 0, rd_hi = 0, cyc = 0;
    int last_done_cyc = 0, gaps = 0, in_frame_err = 0;
    bit gap_chk = 1'b0, prev_in_run = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (tx_done) dones++;
        if (fif.fifo_rd_en) rd_hi++;
        if (!rst_n) begin
            mcnt = -1;
        end else if (mcnt < 0) begin
            if (uart_txd === 1'b0) begin
                starts++;
                if (gap_chk && prev_in_run) begin
                    gaps++;
                    check("gap_high_cycles", cyc - last_done_cyc, RDL + 2);
                end
                smp[0]       = 1'b0;
                in_frame_err = (tx_busy !== 1'b1 || tx_done !== 1'b0) ? 1 : 0;
                mcnt         = 1;
            end
        end else if (mcnt < FRAME) begin
            smp[mcnt] = uart_txd;
            if (tx_busy !== 1'b1 || tx_done !== 1'b0) in_frame_err++;
            mcnt++;
        end else begin
            int shape_err;
            logic ref_b;
            logic [DW-1:0] word;
            shape_err = 0;
            for (int b = 0; b < NBITS; b++) begin
                ref_b = (b == 0) ? 1'b0 : (b == NBITS - 1) ? 1'b1 : smp[b*CPB];
                for (int s = 0; s < CPB; s++)
                    if (smp[b*CPB+s] !== ref_b) shape_err++;
            end
            for (int i = 0; i < DW; i++) word[i] = smp[(i+1)*CPB + CPB/2];
            check("frame_shape", shape_err, 0);
            check("busy_hi_done_lo_in_frame", in_frame_err, 0);
            check("done_at_frame_end", tx_done, 1'b1);
            check("busy_low_after_stop", tx_busy, 1'b0);
            if (exp_q.size() == 0) check("unexpected_frame", 1, 0);
            else                   check("frame_data", word, exp_q.pop_front());
            last_done_cyc = cyc;
            prev_in_run   = gap_chk;
            frames++;
            mcnt = -1;
        end
    end

    task automatic wait_frames(input int n, input int budget, input string what);
        int i = 0;
        while (frames < n && i < budget) begin @(negedge clk); i++; end
        if (frames < n) begin
            total++; bad++;
            $display("FAIL timeout_%s: frames=%0d required %0d", what, frames, n);
        end
    endtask

    task automatic wait_starts(input int n, input int budget, input string what);
        int i = 0;
        while (starts < n && i < budget) begin @(negedge clk); i++; end
        if (starts < n) begin
            total++; bad++;
            $display("FAIL timeout_%s: starts=%0d required %0d", what, starts, n);
        end
    endtask

    typedef struct {
        bit            even;
        logic [DW-1:0] data;
        logic          par;
    } par_vec_t;

    task automatic run_parity(input par_vec_t v, input int idx);
        bit seen = 1'b0;
        p_data = v.data;
        if (v.even) p_en_e = 1'b1; else p_en_o = 1'b1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if ((v.even ? txd_e : txd_o) === 1'b0) seen = 1'b1;
        end
        p_en_o = 1'b0;
        p_en_e = 1'b0;
        if (!seen) begin
            total++; bad++;
            $display("FAIL timeout_parity_start[%0d]: no start bit", idx);
        end else begin
            repeat ((DW + 1) * CPB + CPB/2) @(negedge clk);
            check($sformatf("parity_bit[%0d]", idx), v.even ? txd_e : txd_o, v.par);
            repeat (CPB) @(negedge clk);
            check($sformatf("parity_stop[%0d]", idx), v.even ? txd_e : txd_o, 1'b1);
        end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        par_vec_t pv[5];
        int err, p0, d0, f0, s0;
        pv[0] = '{even: 1'b0, data: 8'h03, par: 1'b1};
        pv[1] = '{even: 1'b1, data: 8'h03, par: 1'b0};
        pv[2] = '{even: 1'b1, data: 8'h07, par: 1'b1};
        pv[3] = '{even: 1'b0, data: 8'h00, par: 1'b1};
        pv[4] = '{even: 1'b1, data: 8'hFF, par: 1'b0};

        rst_n  = 1'b0;
        tx_en  = 1'b0;
        p_en_o = 1'b0;
        p_en_e = 1'b0;
        p_data = '0;
        repeat (3) @(negedge clk);
        check("reset_txd", uart_txd, 1'b1);
        check("reset_rd_en", fif.fifo_rd_en, 1'b0);
        check("reset_busy", tx_busy, 1'b0);
        check("reset_done", tx_done, 1'b0);
        rst_n = 1'b1;

        // Enabled but empty: never pops, line idles
        tx_en = 1'b1;
        err   = 0;
        repeat (100) begin
            @(negedge clk);
            if (fif.fifo_rd_en !== 1'b0 || uart_txd !== 1'b1 || tx_busy !== 1'b0) err++;
        end
        check("empty_idle_violations", err, 0);
        check("empty_pops", pops, 0);

        // Single word 0xA5
        push(8'hA5);
        wait_frames(1, 200, "single");
        repeat (10) @(negedge clk);
        check("single_pops", pops, 1);
        check("single_rd_en_cycles", rd_hi, 1);
        check("single_dones", dones, 1);

        // Back-to-back burst
        gap_chk = 1'b1;
        push(8'h01); push(8'h80); push(8'hFF);
        wait_frames(4, 600, "burst");
        repeat (10) @(negedge clk);
        gap_chk = 1'b0;
        check("burst_pops", pops, 4);
        check("burst_rd_en_cycles", rd_hi, 4);
        check("burst_gaps_seen", gaps, 2);
        check("burst_dones", dones, 4);

        // Parity variants
        for (int i = 0; i < 5; i++) run_parity(pv[i], i);

        // tx_en drop in data bit 3 with two more words queued
        s0 = starts; f0 = frames; p0 = pops;
        push(8'h5A); push(8'h11); push(8'h22);
        wait_starts(s0 + 1, 100, "txen_drop_start");
        repeat (4*CPB + 1) @(negedge clk);
        tx_en = 1'b0;
        wait_frames(f0 + 1, 200, "txen_drop_frame");
        repeat (30) @(negedge clk);
        check("txen_drop_pops", pops, p0 + 1);
        check("txen_drop_busy", tx_busy, 1'b0);
        check("txen_drop_left_in_fifo", byte_q.size(), 2);

        // Reset during data bit 4 of 0x11; 0x22 follows intact
        s0 = starts; f0 = frames;
        tx_en = 1'b1;
        wait_starts(s0 + 1, 100, "reset_start");
        repeat (5*CPB + 1) @(negedge clk);
        d0 = dones;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_txd", uart_txd, 1'b1);
        check("async_reset_busy", tx_busy, 1'b0);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_frames(f0 + 1, 200, "after_reset");
        repeat (10) @(negedge clk);
        check("after_reset_dones", dones, d0 + 1);
        check("after_reset_pops", pops, p0 + 3);
        check("scoreboard_empty", exp_q.size(), 0);
        check("no_underflow", underflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
